ls_queue: RTL and testbench
===========================

Name: ls_queue

Overview:
- In-order load/store queue between the decoder/dispatch stage and the memory controller.
- Holds dispatched loads and stores and resolves their operands by snooping both CDBs.
- Issues one memory access at a time from the queue head; stores issue only after the ROB commits them.
- Broadcasts load results on the LS CDB, which feeds the ROB, the RS and this queue.

Parameters:
LSQ_SIZE, 8, number of queue entries (power of two)
ROB_WIDTH, 4, ROB tag width; tag 0 means "none"
DATA_WIDTH, 32, data/address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_alloc_valid  in  1  allocate one entry this cycle
in_alloc_is_store  in  1  1 = store, 0 = load
in_alloc_funct3  in  3  width: 000 b, 001 h, 010 w, 100 bu, 101 hu
in_alloc_rob_tag  in  ROB_WIDTH  ROB entry of the instruction
in_alloc_imm  in  DATA_WIDTH  sign-extended offset
in_alloc_qj  in  ROB_WIDTH  base operand tag; 0 = value valid
in_alloc_vj  in  DATA_WIDTH  base operand value
in_alloc_qk  in  ROB_WIDTH  store-data tag; 0 = value valid
in_alloc_vk  in  DATA_WIDTH  store-data value
in_cdb_rob_tag  in  ROB_WIDTH  ALU CDB tag; 0 = idle
in_cdb_value  in  DATA_WIDTH  ALU CDB value
in_committed_rob_tag  in  ROB_WIDTH  one-cycle commit pulse for a store; 0 = none
in_misbranch  in  1  flush request from the ROB
out_full  out  1  no free entry
out_ls_cdb_rob_tag  out  ROB_WIDTH  LS CDB tag; 0 = idle
out_ls_cdb_value  out  DATA_WIDTH  loaded value, extended
out_mem_req  out  1  memory request valid
out_mem_we  out  1  1 = write
out_mem_addr  out  DATA_WIDTH  byte address
out_mem_wdata  out  DATA_WIDTH  store data, low-aligned
out_mem_width  out  2  0 = byte, 1 = half, 2 = word
in_mem_done  in  1  one-cycle completion pulse
in_mem_rdata  in  DATA_WIDTH  read data, valid with in_mem_done, low-aligned

Behaviour:
- Reset: head=0, tail=0, count=0, all entries invalid, FSM=IDLE; every output 0 (out_full=0).
- Queue structure
  - Circular queue of LSQ_SIZE entries; pointer width log2(LSQ_SIZE); wrap from LSQ_SIZE-1 to 0.
  - out_full = (count==LSQ_SIZE), combinational.
  - Allocation while full is ignored; the dispatcher must not assert it.
- Allocation: on in_alloc_valid, write the entry at tail, tail++, count++.
  - If the incoming qj/qk matches either CDB tag this same cycle, capture the CDB value and clear the tag.
  - committed=0 on allocation.
- Snoop, every cycle, every valid entry:
  - A qj/qk equal to nonzero in_cdb_rob_tag or nonzero out_ls_cdb_rob_tag takes that value and its tag clears.
- Commit: an entry whose rob_tag equals nonzero in_committed_rob_tag gets committed=1. Loads ignore this flag.
- FSM states IDLE, WAIT_MEM, BCAST.
  - IDLE -> WAIT_MEM when count>0 and head qj==0 and, for a store, qk==0 and committed==1.
    - Register out_mem_req=1, out_mem_addr=vj+imm (mod 2^DATA_WIDTH), out_mem_we, out_mem_width=funct3[1:0], out_mem_wdata=vk.
    - The request is registered, so it is visible the cycle after the decision.
  - WAIT_MEM holds the request stable until in_mem_done.
    - Store: drop out_mem_req, pop head, -> IDLE.
    - Load: latch the extended rdata, drop out_mem_req, -> BCAST.
  - BCAST drives out_ls_cdb_rob_tag/value for exactly one cycle, pops head, -> IDLE.
  - The LS CDB is 0 in all other cycles.
- Minimum latency: load allocated with ready base to LS CDB = 3 cycles plus memory latency.
- Extension: lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw passes through.
- Simultaneous pop and allocate: count unchanged, both pointers advance.
- Misbranch, registered, takes effect the next edge:
  - Discard every entry with committed==0, but keep a store at head that is already issued.
  - tail = index after the last committed entry (committed stores form a contiguous run from head); count adjusted to match.
  - An in-flight load finishes its memory handshake, is popped, and is never broadcast; FSM -> IDLE.
  - An allocation in the same cycle as a misbranch is dropped.
- rst mid-operation: immediate return to the reset state; out_mem_req drops on the next edge; any pending in_mem_done is ignored.

Test Plan:
- Reset, then lw with vj=0x100, imm=4, qj=0; mem returns 0xDEADBEEF -> out_mem_addr=0x104, width=2, we=0; LS CDB shows tag 3, value 0xDEADBEEF for one cycle.
- lb with rdata=0x00000080 -> value 0xFFFFFF80; lbu with the same rdata -> 0x00000080.
- Store qj=5, then CDB broadcasts tag 5 value 0x200, imm=0 -> no request until commit pulse of its tag; then write to 0x200 with we=1.
- Fill 8 entries -> out_full=1; an extra alloc is ignored; one pop -> out_full=0 next cycle.
- Committed store plus two loads queued, misbranch -> store still writes memory; both loads vanish; no LS CDB activity; count=0 afterwards.
- Load in WAIT_MEM when misbranch arrives -> in_mem_done accepted, no broadcast, queue empty, FSM back in IDLE.

Source files
------------

// File: rtl/ls_queue.sv
// In-order load/store queue: snoops both CDBs for operands, issues one memory
// access at a time from the head, and broadcasts load results on the LS CDB.
module ls_queue #(
    parameter int unsigned LSQ_SIZE   = 8,
    parameter int unsigned ROB_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_alloc_valid,
    input  logic                  in_alloc_is_store,
    input  logic [2:0]            in_alloc_funct3,
    input  logic [ROB_WIDTH-1:0]  in_alloc_rob_tag,
    input  logic [DATA_WIDTH-1:0] in_alloc_imm,
    input  logic [ROB_WIDTH-1:0]  in_alloc_qj,
    input  logic [DATA_WIDTH-1:0] in_alloc_vj,
    input  logic [ROB_WIDTH-1:0]  in_alloc_qk,
    input  logic [DATA_WIDTH-1:0] in_alloc_vk,
    input  logic [ROB_WIDTH-1:0]  in_cdb_rob_tag,
    input  logic [DATA_WIDTH-1:0] in_cdb_value,
    input  logic [ROB_WIDTH-1:0]  in_committed_rob_tag,
    input  logic                  in_misbranch,
    output logic                  out_full,
    output logic [ROB_WIDTH-1:0]  out_ls_cdb_rob_tag,
    output logic [DATA_WIDTH-1:0] out_ls_cdb_value,
    output logic                  out_mem_req,
    output logic                  out_mem_we,
    output logic [DATA_WIDTH-1:0] out_mem_addr,
    output logic [DATA_WIDTH-1:0] out_mem_wdata,
    output logic [1:0]            out_mem_width,
    input  logic                  in_mem_done,
    input  logic [DATA_WIDTH-1:0] in_mem_rdata
);
    localparam int unsigned PTR_W = $clog2(LSQ_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, BCAST} state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d, keep_c;
    logic                    kill_q, kill_d;
    logic                    mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [1:0]              mem_width_q, mem_width_d;
    logic [ROB_WIDTH-1:0]    ls_tag_q, ls_tag_d;
    logic [DATA_WIDTH-1:0]   ls_val_q, ls_val_d;
    logic                    pop_c, push_c, head_ready_c;
    logic [ROB_WIDTH-1:0]    alloc_qj_c, alloc_qk_c;
    logic [DATA_WIDTH-1:0]   alloc_vj_c, alloc_vk_c;

    logic                    is_store_q  [LSQ_SIZE];
    logic                    committed_q [LSQ_SIZE];
    logic [2:0]              funct3_q    [LSQ_SIZE];
    logic [ROB_WIDTH-1:0]    rob_tag_q   [LSQ_SIZE];
    logic [ROB_WIDTH-1:0]    qj_q        [LSQ_SIZE];
    logic [ROB_WIDTH-1:0]    qk_q        [LSQ_SIZE];
    logic [DATA_WIDTH-1:0]   imm_q       [LSQ_SIZE];
    logic [DATA_WIDTH-1:0]   vj_q        [LSQ_SIZE];
    logic [DATA_WIDTH-1:0]   vk_q        [LSQ_SIZE];

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [2:0] f3,
                                                     input logic [DATA_WIDTH-1:0] d);
        case (f3)
            3'b000:  return {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
            3'b001:  return {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
            3'b100:  return DATA_WIDTH'(d[7:0]);
            3'b101:  return DATA_WIDTH'(d[15:0]);
            default: return d;
        endcase
    endfunction

    assign out_full           = (count_q == CNT_W'(LSQ_SIZE));
    assign out_ls_cdb_rob_tag = ls_tag_q;
    assign out_ls_cdb_value   = ls_val_q;
    assign out_mem_req        = mem_req_q;
    assign out_mem_we         = mem_we_q;
    assign out_mem_addr       = mem_addr_q;
    assign out_mem_wdata      = mem_wdata_q;
    assign out_mem_width      = mem_width_q;

    assign push_c       = in_alloc_valid && !out_full && !in_misbranch;
    assign head_ready_c = (count_q != '0) && (qj_q[head_q] == '0) &&
                          (!is_store_q[head_q] || (qk_q[head_q] == '0 && committed_q[head_q]));

    // Operands arriving on either CDB in the allocation cycle are captured directly.
    always_comb begin
        alloc_qj_c = in_alloc_qj;
        alloc_vj_c = in_alloc_vj;
        alloc_qk_c = in_alloc_qk;
        alloc_vk_c = in_alloc_vk;
        if (in_alloc_qj != '0 && in_alloc_qj == in_cdb_rob_tag) begin
            alloc_qj_c = '0;
            alloc_vj_c = in_cdb_value;
        end else if (in_alloc_qj != '0 && in_alloc_qj == ls_tag_q) begin
            alloc_qj_c = '0;
            alloc_vj_c = ls_val_q;
        end
        if (in_alloc_qk != '0 && in_alloc_qk == in_cdb_rob_tag) begin
            alloc_qk_c = '0;
            alloc_vk_c = in_cdb_value;
        end else if (in_alloc_qk != '0 && in_alloc_qk == ls_tag_q) begin
            alloc_qk_c = '0;
            alloc_vk_c = ls_val_q;
        end
    end

    // FSM next-state and registered memory/LS-CDB outputs.
    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        pop_c       = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_width_d = mem_width_q;
        ls_tag_d    = '0;
        ls_val_d    = '0;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (head_ready_c && !in_misbranch) begin
                    state_d     = WAIT_MEM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = is_store_q[head_q];
                    mem_addr_d  = vj_q[head_q] + imm_q[head_q];
                    mem_wdata_d = vk_q[head_q];
                    mem_width_d = funct3_q[head_q][1:0];
                end
            end
            WAIT_MEM: begin
                if (in_mem_done) begin
                    mem_req_d = 1'b0;
                    if (is_store_q[head_q] || kill_q || in_misbranch) begin
                        pop_c   = 1'b1;
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        ls_tag_d = rob_tag_q[head_q];
                        ls_val_d = extend(funct3_q[head_q], in_mem_rdata);
                        state_d  = BCAST;
                    end
                end else if (in_misbranch && !is_store_q[head_q]) begin
                    kill_d = 1'b1;
                end
            end
            BCAST: begin
                pop_c   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer update; a flush keeps the committed-store run from head plus any in-flight head.
    always_comb begin
        logic             run;
        logic [PTR_W-1:0] idx;
        keep_c = '0;
        run    = 1'b1;
        for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
            idx = head_q + PTR_W'(i);
            if (run && CNT_W'(i) < count_q &&
                ((is_store_q[idx] && committed_q[idx]) || (i == 0 && state_q != IDLE)))
                keep_c = keep_c + CNT_W'(1);
            else
                run = 1'b0;
        end
        head_d = head_q + PTR_W'(pop_c);
        if (in_misbranch) begin
            tail_d  = head_q + keep_c[PTR_W-1:0];
            count_d = keep_c - CNT_W'(pop_c);
        end else begin
            tail_d  = tail_q + PTR_W'(push_c);
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            kill_q      <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_width_q <= '0;
            ls_tag_q    <= '0;
            ls_val_q    <= '0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_width_q <= mem_width_d;
            ls_tag_q    <= ls_tag_d;
            ls_val_q    <= ls_val_d;
        end
    end

    // Entry storage: CDB snoop, commit marking, then allocation at tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
                committed_q[PTR_W'(i)] <= 1'b0;
                qj_q[PTR_W'(i)]        <= '0;
                qk_q[PTR_W'(i)]        <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
                if (qj_q[PTR_W'(i)] != '0 && qj_q[PTR_W'(i)] == in_cdb_rob_tag) begin
                    qj_q[PTR_W'(i)] <= '0;
                    vj_q[PTR_W'(i)] <= in_cdb_value;
                end else if (qj_q[PTR_W'(i)] != '0 && qj_q[PTR_W'(i)] == ls_tag_q) begin
                    qj_q[PTR_W'(i)] <= '0;
                    vj_q[PTR_W'(i)] <= ls_val_q;
                end
                if (qk_q[PTR_W'(i)] != '0 && qk_q[PTR_W'(i)] == in_cdb_rob_tag) begin
                    qk_q[PTR_W'(i)] <= '0;
                    vk_q[PTR_W'(i)] <= in_cdb_value;
                end else if (qk_q[PTR_W'(i)] != '0 && qk_q[PTR_W'(i)] == ls_tag_q) begin
                    qk_q[PTR_W'(i)] <= '0;
                    vk_q[PTR_W'(i)] <= ls_val_q;
                end
                if (in_committed_rob_tag != '0 && rob_tag_q[PTR_W'(i)] == in_committed_rob_tag)
                    committed_q[PTR_W'(i)] <= 1'b1;
            end
            if (push_c) begin
                is_store_q[tail_q]  <= in_alloc_is_store;
                committed_q[tail_q] <= 1'b0;
                funct3_q[tail_q]    <= in_alloc_funct3;
                rob_tag_q[tail_q]   <= in_alloc_rob_tag;
                imm_q[tail_q]       <= in_alloc_imm;
                qj_q[tail_q]        <= alloc_qj_c;
                vj_q[tail_q]        <= alloc_vj_c;
                qk_q[tail_q]        <= alloc_qk_c;
                vk_q[tail_q]        <= alloc_vk_c;
            end
        end
    end

endmodule

// File: tb/tb_ls_queue.sv
// Directed bench for ls_queue: hand-computed expectations for issue, extension,
// store commit gating, full handling, flush and reset behaviour.
module tb_ls_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_alloc_valid, in_alloc_is_store;
    logic [2:0]  in_alloc_funct3;
    logic [3:0]  in_alloc_rob_tag, in_alloc_qj, in_alloc_qk;
    logic [31:0] in_alloc_imm, in_alloc_vj, in_alloc_vk;
    logic [3:0]  in_cdb_rob_tag, in_committed_rob_tag;
    logic [31:0] in_cdb_value;
    logic        in_misbranch;
    logic        out_full;
    logic [3:0]  out_ls_cdb_rob_tag;
    logic [31:0] out_ls_cdb_value;
    logic        out_mem_req, out_mem_we;
    logic [31:0] out_mem_addr, out_mem_wdata;
    logic [1:0]  out_mem_width;
    logic        in_mem_done;
    logic [31:0] in_mem_rdata;

    int errors = 0;
    int checks = 0;

    ls_queue dut (
        .clk(clk), .rst(rst),
        .in_alloc_valid(in_alloc_valid), .in_alloc_is_store(in_alloc_is_store),
        .in_alloc_funct3(in_alloc_funct3), .in_alloc_rob_tag(in_alloc_rob_tag),
        .in_alloc_imm(in_alloc_imm), .in_alloc_qj(in_alloc_qj), .in_alloc_vj(in_alloc_vj),
        .in_alloc_qk(in_alloc_qk), .in_alloc_vk(in_alloc_vk),
        .in_cdb_rob_tag(in_cdb_rob_tag), .in_cdb_value(in_cdb_value),
        .in_committed_rob_tag(in_committed_rob_tag), .in_misbranch(in_misbranch),
        .out_full(out_full), .out_ls_cdb_rob_tag(out_ls_cdb_rob_tag),
        .out_ls_cdb_value(out_ls_cdb_value), .out_mem_req(out_mem_req),
        .out_mem_we(out_mem_we), .out_mem_addr(out_mem_addr),
        .out_mem_wdata(out_mem_wdata), .out_mem_width(out_mem_width),
        .in_mem_done(in_mem_done), .in_mem_rdata(in_mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic st, input logic [2:0] f3, input logic [3:0] tag,
                         input logic [31:0] imm, input logic [3:0] qj, input logic [31:0] vj,
                         input logic [3:0] qk, input logic [31:0] vk);
        in_alloc_valid    = 1'b1;
        in_alloc_is_store = st;
        in_alloc_funct3   = f3;
        in_alloc_rob_tag  = tag;
        in_alloc_imm      = imm;
        in_alloc_qj       = qj;
        in_alloc_vj       = vj;
        in_alloc_qk       = qk;
        in_alloc_vk       = vk;
        tick();
        in_alloc_valid    = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!out_mem_req && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(out_mem_req), 32'd1);
    endtask

    task automatic respond(input logic [31:0] d);
        in_mem_done  = 1'b1;
        in_mem_rdata = d;
        tick();
        in_mem_done  = 1'b0;
        in_mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_req, seen_cdb;
        rst = 1'b1;
        in_alloc_valid = 0; in_alloc_is_store = 0; in_alloc_funct3 = 0; in_alloc_rob_tag = 0;
        in_alloc_imm = 0; in_alloc_qj = 0; in_alloc_vj = 0; in_alloc_qk = 0; in_alloc_vk = 0;
        in_cdb_rob_tag = 0; in_cdb_value = 0; in_committed_rob_tag = 0; in_misbranch = 0;
        in_mem_done = 0; in_mem_rdata = 0;
        tick(); tick();
        rst = 1'b0;
        check("rst_full", 32'(out_full), 0);
        check("rst_req", 32'(out_mem_req), 0);
        check("rst_cdb_tag", 32'(out_ls_cdb_rob_tag), 0);
        check("rst_addr", out_mem_addr, 0);

        // lw: decision cycle, then registered request
        alloc(0, 3'b010, 4'd3, 32'd4, 4'd0, 32'h100, 4'd0, 32'd0);
        check("lw_req_latency", 32'(out_mem_req), 0);
        tick();
        check("lw_req", 32'(out_mem_req), 1);
        check("lw_addr", out_mem_addr, 32'h104);
        check("lw_width", 32'(out_mem_width), 2);
        check("lw_we", 32'(out_mem_we), 0);
        respond(32'hDEADBEEF);
        check("lw_cdb_tag", 32'(out_ls_cdb_rob_tag), 3);
        check("lw_cdb_val", out_ls_cdb_value, 32'hDEADBEEF);
        check("lw_req_drop", 32'(out_mem_req), 0);
        tick();
        check("lw_cdb_one_cycle", 32'(out_ls_cdb_rob_tag), 0);

        // lb / lbu extension
        alloc(0, 3'b000, 4'd4, 32'd0, 4'd0, 32'h10, 4'd0, 32'd0);
        wait_req("lb_req");
        check("lb_width", 32'(out_mem_width), 0);
        respond(32'h00000080);
        check("lb_cdb_tag", 32'(out_ls_cdb_rob_tag), 4);
        check("lb_val", out_ls_cdb_value, 32'hFFFFFF80);
        tick();
        alloc(0, 3'b100, 4'd5, 32'd0, 4'd0, 32'h10, 4'd0, 32'd0);
        wait_req("lbu_req");
        respond(32'h00000080);
        check("lbu_val", out_ls_cdb_value, 32'h00000080);
        tick();
        alloc(0, 3'b001, 4'd6, 32'd2, 4'd0, 32'h20, 4'd0, 32'd0);
        wait_req("lh_req");
        check("lh_addr", out_mem_addr, 32'h22);
        respond(32'h12348001);
        check("lh_val", out_ls_cdb_value, 32'hFFFF8001);
        tick();

        // store waits for base via CDB and for commit
        alloc(1, 3'b010, 4'd6, 32'd0, 4'd5, 32'd0, 4'd0, 32'h55AA);
        in_cdb_rob_tag = 4'd5; in_cdb_value = 32'h200;
        tick();
        in_cdb_rob_tag = 0; in_cdb_value = 0;
        tick(); tick(); tick();
        check("st_no_req_uncommitted", 32'(out_mem_req), 0);
        in_committed_rob_tag = 4'd6;
        tick();
        in_committed_rob_tag = 0;
        wait_req("st_req");
        check("st_we", 32'(out_mem_we), 1);
        check("st_addr", out_mem_addr, 32'h200);
        check("st_wdata", out_mem_wdata, 32'h55AA);
        respond(32'h0);
        check("st_req_drop", 32'(out_mem_req), 0);
        check("st_no_cdb", 32'(out_ls_cdb_rob_tag), 0);
        tick();

        // fill with uncommitted stores
        for (int i = 1; i <= 8; i++)
            alloc(1, 3'b010, 4'(i), 32'd0, 4'd0, 32'h600 + 32'(i * 4), 4'd0, 32'(i));
        check("full_set", 32'(out_full), 1);
        alloc(0, 3'b010, 4'd9, 32'd0, 4'd0, 32'h500, 4'd0, 32'd0);
        check("full_still", 32'(out_full), 1);
        in_committed_rob_tag = 4'd1;
        tick();
        in_committed_rob_tag = 0;
        wait_req("full_head_req");
        check("full_head_we", 32'(out_mem_we), 1);
        check("full_head_addr", out_mem_addr, 32'h604);
        respond(32'h0);
        check("full_clear_after_pop", 32'(out_full), 0);
        alloc(1, 3'b010, 4'd10, 32'd0, 4'd0, 32'h700, 4'd0, 32'd0);
        check("full_refill", 32'(out_full), 1);
        in_misbranch = 1'b1;
        tick();
        in_misbranch = 1'b0;
        check("flush_full_clear", 32'(out_full), 0);

        // committed store survives flush, two loads vanish
        alloc(1, 3'b010, 4'd1, 32'd8, 4'd0, 32'h300, 4'd0, 32'h1234);
        alloc(0, 3'b010, 4'd2, 32'd0, 4'd0, 32'h800, 4'd0, 32'd0);
        alloc(0, 3'b010, 4'd3, 32'd0, 4'd0, 32'h900, 4'd0, 32'd0);
        in_committed_rob_tag = 4'd1;
        tick();
        in_committed_rob_tag = 0;
        in_misbranch = 1'b1;
        tick();
        in_misbranch = 1'b0;
        wait_req("mb_st_req");
        check("mb_st_we", 32'(out_mem_we), 1);
        check("mb_st_addr", out_mem_addr, 32'h308);
        check("mb_st_wdata", out_mem_wdata, 32'h1234);
        respond(32'h0);
        seen_req = 0; seen_cdb = 0;
        for (int i = 0; i < 6; i++) begin
            seen_req |= out_mem_req;
            seen_cdb |= (out_ls_cdb_rob_tag != 0);
            tick();
        end
        check("mb_loads_gone_req", 32'(seen_req), 0);
        check("mb_loads_gone_cdb", 32'(seen_cdb), 0);

        // load in flight when flush arrives
        alloc(0, 3'b010, 4'd7, 32'd0, 4'd0, 32'h400, 4'd0, 32'd0);
        wait_req("inflight_req");
        in_misbranch = 1'b1;
        tick();
        in_misbranch = 1'b0;
        check("inflight_req_hold", 32'(out_mem_req), 1);
        check("inflight_addr_hold", out_mem_addr, 32'h400);
        respond(32'h99);
        check("inflight_no_cdb", 32'(out_ls_cdb_rob_tag), 0);
        check("inflight_req_drop", 32'(out_mem_req), 0);
        tick();
        check("inflight_no_cdb_later", 32'(out_ls_cdb_rob_tag), 0);
        alloc(0, 3'b010, 4'd8, 32'd0, 4'd0, 32'hA00, 4'd0, 32'd0);
        check("post_flush_idle", 32'(out_mem_req), 0);
        tick();
        check("post_flush_issue", 32'(out_mem_req), 1);
        check("post_flush_addr", out_mem_addr, 32'hA00);
        respond(32'h77);
        check("post_flush_cdb_tag", 32'(out_ls_cdb_rob_tag), 8);
        check("post_flush_cdb_val", out_ls_cdb_value, 32'h77);
        tick();

        // reset mid-operation ignores the pending completion
        alloc(0, 3'b010, 4'd9, 32'd0, 4'd0, 32'hB00, 4'd0, 32'd0);
        wait_req("rst_mid_req");
        rst = 1'b1;
        in_mem_done = 1'b1; in_mem_rdata = 32'h1;
        tick();
        rst = 1'b0;
        in_mem_done = 1'b0; in_mem_rdata = 0;
        check("rst_mid_req_drop", 32'(out_mem_req), 0);
        check("rst_mid_no_cdb", 32'(out_ls_cdb_rob_tag), 0);
        tick(); tick();
        check("rst_mid_empty", 32'(out_mem_req), 0);
        check("rst_mid_addr", out_mem_addr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
